// File: rtl/dot_tracker_pkg.sv
// Shared maze geometry, FSM state encoding and a BCD increment helper
// for the dot tracker.
package dot_tracker_pkg;

    localparam int TILES_X = 28;
    localparam int TILES_Y = 36;
    localparam int N_TILES = TILES_X * TILES_Y;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        LOOKUP,
        EAT
    } state_t;

    // Three-digit BCD +1; 999 rolls over to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] value);
        logic [11:0] r;
        r = value;
        if (r[3:0] != 4'd9) begin
            r[3:0] = r[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd9) begin
                r[7:4] = r[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_tracker_rom.sv
// Initial dot map ROM, one bit per tile, one-cycle synchronous read.
// DOT_MAP supplies the contents.
module dot_rom #(
    parameter string DOT_FILE = "level_dots.bin",
    parameter int N_TILES = 1008,
    parameter logic [N_TILES-1:0] DOT_MAP = '0
) (
    input  logic       clk,
    input  logic [9:0] addr,
    output logic       data
);

    logic mem [N_TILES];

    initial begin
        for (int k = 0; k < N_TILES; k++) mem[k] = DOT_MAP[k];
    end

    always_ff @(posedge clk) begin
        data <= (int'(addr) < N_TILES) ? mem[addr] : 1'b0;
    end

endmodule

// File: rtl/dot_tracker.sv
// Tracks which maze dots remain, consumes the dot under Pac-Man once per
// frame and keeps the remaining-dot count and BCD score.
module dot_tracker #(
    parameter string DOT_FILE = "level_dots.bin",
    parameter int N_TILES = dot_tracker_pkg::N_TILES,
    parameter logic [N_TILES-1:0] DOT_MAP = '0
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        pac_valid,
    input  logic [4:0]  pac_tile_x,
    input  logic [5:0]  pac_tile_y,
    input  logic [9:0]  query_index,
    output logic        query_dot,
    output logic        busy,
    output logic        eat_pulse,
    output logic [7:0]  dots_left,
    output logic [11:0] score_bcd,
    output logic        level_clear
);

    import dot_tracker_pkg::*;

    localparam logic [9:0] LAST_TILE = 10'(N_TILES - 1);
    localparam logic [9:0] IDX_END   = 10'(N_TILES);

    state_t     state, state_next;
    logic [9:0] i, i_next;
    logic [9:0] idx;
    logic [9:0] y_ext, pac_idx;
    logic       pac_ok;
    logic       rom_bit, lookup_bit;
    logic       live [N_TILES];
    logic       live_we, live_data, query_en;
    logic [9:0] live_addr;

    // y*28 + x built from shifts: y*32 - y*4 + x.
    assign y_ext   = {4'd0, pac_tile_y};
    assign pac_idx = (y_ext << 5) - (y_ext << 2) + {5'd0, pac_tile_x};
    assign pac_ok  = frame_tick && pac_valid &&
                     (pac_tile_x <= 5'(TILES_X - 1)) && (pac_tile_y <= 6'(TILES_Y - 1));

    assign busy = (state == INIT);

    always_comb begin
        state_next = state;
        i_next     = '0;
        case (state)
            INIT: begin
                if (i == LAST_TILE) state_next = IDLE;
                else                i_next     = i + 10'd1;
            end
            IDLE:    if (pac_ok) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_bit ? EAT : IDLE;
            EAT:     state_next = (dots_left == 8'd1) ? INIT : IDLE;
            default: state_next = INIT;
        endcase
        if (!rst_n) begin
            state_next = INIT;
            i_next     = '0;
        end
    end

    // The ROM is addressed with i_next so rom_bit already holds rom[i] during INIT.
    dot_rom #(
        .DOT_FILE(DOT_FILE),
        .N_TILES (N_TILES),
        .DOT_MAP (DOT_MAP)
    ) u_rom (
        .clk (pclk),
        .addr(i_next),
        .data(rom_bit)
    );

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= INIT;
            i     <= '0;
        end else begin
            state <= state_next;
            i     <= i_next;
        end
    end

    assign live_we   = rst_n && (state == INIT || state == EAT);
    assign live_addr = (state == INIT) ? i : idx;
    assign live_data = (state == INIT) ? rom_bit : 1'b0;
    assign query_en  = (state != INIT) && (state_next != INIT) && (query_index < IDX_END);

    always_ff @(posedge pclk) begin
        if (live_we) live[live_addr] <= live_data;
        lookup_bit <= (pac_idx < IDX_END) ? live[pac_idx] : 1'b0;
        query_dot  <= query_en ? live[query_index] : 1'b0;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            idx         <= '0;
            dots_left   <= '0;
            score_bcd   <= '0;
            eat_pulse   <= 1'b0;
            level_clear <= 1'b0;
        end else begin
            eat_pulse   <= 1'b0;
            level_clear <= 1'b0;
            if (state == IDLE && pac_ok) idx <= pac_idx;
            case (state)
                INIT: if (rom_bit && dots_left != 8'hFF) dots_left <= dots_left + 8'd1;
                EAT: begin
                    eat_pulse <= 1'b1;
                    score_bcd <= bcd_inc(score_bcd);
                    if (dots_left != 8'd0) dots_left   <= dots_left - 8'd1;
                    if (dots_left == 8'd1) level_clear <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_tracker.sv
// Randomized scoreboard bench for dot_tracker against a map/counter model.
module tb_dot_tracker;

    localparam int N = 1008;
    localparam int MAP_DOTS = 244;

    // Every fourth tile starting at 1, below 976: 244 dots, including tile (1,4).
    function automatic logic [N-1:0] make_map();
        logic [N-1:0] m;
        m = '0;
        for (int k = 1; k < 976; k += 4) m[k] = 1'b1;
        return m;
    endfunction

    localparam logic [N-1:0] MAP = make_map();

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        pac_valid = 1'b0;
    logic [4:0]  pac_tile_x = '0;
    logic [5:0]  pac_tile_y = '0;
    logic [9:0]  query_index = '0;
    logic        query_dot, busy, eat_pulse, level_clear;
    logic [7:0]  dots_left;
    logic [11:0] score_bcd;

    dot_tracker #(
        .DOT_FILE(""),
        .N_TILES (N),
        .DOT_MAP (MAP)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .pac_valid  (pac_valid),
        .pac_tile_x (pac_tile_x),
        .pac_tile_y (pac_tile_y),
        .query_index(query_index),
        .query_dot  (query_dot),
        .busy       (busy),
        .eat_pulse  (eat_pulse),
        .dots_left  (dots_left),
        .score_bcd  (score_bcd),
        .level_clear(level_clear)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          cycle;
        logic [7:0]  left;
        logic [11:0] score;
        logic        clear;
    } eat_t;

    typedef struct {
        int   cycle;
        logic dot;
    } qry_t;

    eat_t eat_q[$];
    qry_t qry_q[$];
    eat_t mon_eat;
    qry_t mon_qry;

    int checks = 0;
    int fails  = 0;

    logic model_map [N];
    int   model_left;
    int   model_score;
    int   total_eaten = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reload();
        for (int k = 0; k < N; k++) model_map[k] = MAP[k];
        model_left = MAP_DOTS;
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an eat or a query result is due.
    always @(negedge pclk) begin
        if (rst_n) begin
            if (eat_pulse) begin
                if (eat_q.size() == 0) begin
                    check_output("unexpected_eat", 1, 0);
                end else begin
                    mon_eat = eat_q.pop_front();
                    check_output("eat_cycle", cyc, mon_eat.cycle);
                    check_output("eat_dots_left", dots_left, mon_eat.left);
                    check_output("eat_score_bcd", score_bcd, mon_eat.score);
                    check_output("eat_level_clear", level_clear, mon_eat.clear);
                end
            end else if (level_clear) begin
                check_output("stray_level_clear", 1, 0);
            end
            if (eat_q.size() > 0 && eat_q[0].cycle < cyc) begin
                check_output("missing_eat", 0, 1);
                void'(eat_q.pop_front());
            end
            if (qry_q.size() > 0 && qry_q[0].cycle <= cyc) begin
                mon_qry = qry_q.pop_front();
                if (mon_qry.cycle == cyc) check_output("query_dot", query_dot, mon_qry.dot);
                else                      check_output("query_late", 0, 1);
            end
        end
    end

    // Called on the negedge of the first INIT cycle; measures INIT length.
    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            n++;
            @(negedge pclk);
        end
        check_output({tag, "_init_cycles"}, n, N);
        check_output({tag, "_dots_after_init"}, dots_left, MAP_DOTS);
    endtask

    task automatic reset_and_wait(input string tag);
        rst_n = 1'b0;
        frame_tick = 1'b0;
        query_index = 10'd113;
        repeat (3) @(negedge pclk);
        check_output({tag, "_rst_busy"}, busy, 1);
        check_output({tag, "_rst_dots_left"}, dots_left, 0);
        check_output({tag, "_rst_score"}, score_bcd, 0);
        check_output({tag, "_rst_eat_pulse"}, eat_pulse, 0);
        check_output({tag, "_rst_level_clear"}, level_clear, 0);
        check_output({tag, "_rst_query_dot"}, query_dot, 0);
        rst_n = 1'b1;
        model_reload();
        model_score = 0;
        count_init(tag);
    endtask

    // One frame tick at a negedge, optional ignored repeat tick in the
    // LOOKUP cycle, then a query on the cycle the eat result appears.
    task automatic apply_stimulus(input int x, input int y, input logic valid,
                                  input logic second, input int q);
        int   t;
        int   ti;
        logic clear;
        clear = 1'b0;
        t = cyc;
        frame_tick = 1'b1;
        pac_valid  = valid;
        pac_tile_x = 5'(x);
        pac_tile_y = 6'(y);
        if (valid && x <= 27 && y <= 35) begin
            ti = y * 28 + x;
            if (model_map[ti]) begin
                model_map[ti] = 1'b0;
                model_left--;
                model_score = (model_score + 1) % 1000;
                total_eaten++;
                clear = (model_left == 0);
                eat_q.push_back('{cycle: t + 3, left: 8'(model_left),
                                  score: to_bcd(model_score), clear: clear});
            end
        end
        @(negedge pclk);
        frame_tick = second;
        @(negedge pclk);
        frame_tick = 1'b0;
        @(negedge pclk);
        query_index = 10'(q);
        if (clear) begin
            qry_q.push_back('{cycle: t + 4, dot: 1'b0});
            model_reload();
            count_init("level");
        end else begin
            qry_q.push_back('{cycle: t + 4, dot: (q < N) ? model_map[q] : 1'b0});
            @(negedge pclk);
        end
    endtask

    initial begin
        int k;
        int x;
        int y;
        int q;
        int txn;
        @(negedge pclk);
        reset_and_wait("boot");

        // Ticks during INIT are ignored; a reset mid-INIT restarts the rebuild.
        rst_n = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;
        pac_valid = 1'b1;
        pac_tile_x = 5'd1;
        pac_tile_y = 6'd4;
        for (int c = 0; c < 400; c++) begin
            frame_tick = c[0];
            @(negedge pclk);
        end
        frame_tick = 1'b0;
        check_output("mid_init_busy", busy, 1);
        reset_and_wait("restart");

        apply_stimulus(1, 4, 1'b1, 1'b0, 113);
        apply_stimulus(1, 4, 1'b1, 1'b1, 113);
        check_output("repeat_dots_left", dots_left, model_left);
        check_output("repeat_score", score_bcd, to_bcd(model_score));
        apply_stimulus(5, 4, 1'b0, 1'b1, 117);
        apply_stimulus(5, 36, 1'b1, 1'b0, 1009);
        check_output("ignored_dots_left", dots_left, model_left);
        check_output("ignored_score", score_bcd, to_bcd(model_score));

        txn = 0;
        while (total_eaten < 1005 && txn < 6000) begin
            txn++;
            if ($urandom_range(0, 9) < 6) begin
                k = $urandom_range(0, N - 1);
                for (int s = 0; s < N && !model_map[k]; s++) k = (k + 1) % N;
                x = k % 28;
                y = k / 28;
                q = ($urandom_range(0, 1) == 0) ? k : $urandom_range(0, 1023);
                apply_stimulus(x, y, 1'b1, 1'($urandom_range(0, 1)), q);
            end else begin
                x = $urandom_range(0, 31);
                y = $urandom_range(0, 40);
                q = $urandom_range(0, 1023);
                apply_stimulus(x, y, 1'($urandom_range(0, 9) != 0),
                               1'($urandom_range(0, 1)), q);
            end
        end
        check_output("eat_progress", int'(total_eaten >= 1005), 1);

        repeat (5) @(negedge pclk);
        check_output("final_dots_left", dots_left, model_left);
        check_output("final_score", score_bcd, to_bcd(model_score));
        check_output("eat_queue_drained", eat_q.size(), 0);
        check_output("query_queue_drained", qry_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dot_tracker.md
DOT_TRACKER -- requirements
Module: dot_tracker

Interface
REQ-001 Parameter: DOT_FILE, default "level_dots.bin", initial dot map with one bit per tile, 1008 lines, 1 = dot present.
REQ-002 Parameter: N_TILES, default 1008, number of tiles (28 x 36).
REQ-003 Port: pclk, input, 1, pixel clock; the only clock.
REQ-004 Port: rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 Port: frame_tick, input, 1, one-cycle pulse per frame.
REQ-006 Port: pac_valid, input, 1, Pac-Man centre is inside the maze.
REQ-007 Port: pac_tile_x, input, 5, Pac-Man centre tile column, 0..27.
REQ-008 Port: pac_tile_y, input, 6, Pac-Man centre tile row, 0..35.
REQ-009 Port: query_index, input, 10, renderer tile index (y*28+x) for the pixel being fetched.
REQ-010 Port: query_dot, output, 1, dot present at query_index; registered.
REQ-011 Port: busy, output, 1, map (re)initialisation in progress.
REQ-012 Port: eat_pulse, output, 1, one-cycle pulse when a dot is consumed.
REQ-013 Port: dots_left, output, 8, remaining dots (binary).
REQ-014 Port: score_bcd, output, 12, dots eaten as three BCD digits, for the HEX displays.
REQ-015 Port: level_clear, output, 1, one-cycle pulse when the last dot is eaten.

Function
REQ-016 Live map: N_TILES x 1 storage. It has one synchronous write port and two synchronous read ports: one for the FSM and one for query.
REQ-017 query_dot shall equal live[query_index] registered one cycle after query_index is presented, matching the maze-ROM latency. It shall be 0 while busy=1 or when query_index >= N_TILES.
REQ-018 FSM states: INIT, IDLE, LOOKUP, EAT.
REQ-019 INIT: a 10-bit counter i steps 0..N_TILES-1, one tile per cycle. Each step copies rom[i] to live[i] and increments dots_left when rom[i]=1. At i=N_TILES-1 the FSM goes to IDLE.
REQ-020 busy shall be 1 exactly while in INIT. From reset release, INIT lasts N_TILES cycles.
REQ-021 IDLE: when frame_tick=1, pac_valid=1, pac_tile_x<=27 and pac_tile_y<=35, the FSM latches idx = pac_tile_y*28 + pac_tile_x (computed as y*32 - y*4 + x, 10 bits) and goes to LOOKUP. Otherwise it stays in IDLE.
REQ-022 LOOKUP: the FSM reads live[idx]. If the bit is 1 it goes to EAT; otherwise it goes to IDLE.
REQ-023 EAT: the FSM shall:
  - write live[idx]=0;
  - pulse eat_pulse;
  - decrement dots_left;
  - increment score_bcd with a BCD carry per digit, wrapping 999 to 000.
  All of these update on the same edge.
REQ-024 Latency: for a frame_tick in cycle T that hits a dot, eat_pulse shall be high in cycle T+3. The new dots_left and score_bcd values shall be visible from cycle T+3.
REQ-025 EAT with dots_left=1: level_clear shall pulse in the same cycle as eat_pulse, and the next state shall be INIT. In that INIT, score_bcd is kept and dots_left restarts from 0.
REQ-026 The FSM shall ignore frame_tick in INIT, LOOKUP and EAT; ticks are not queued.
REQ-027 A tile that has already been eaten shall produce no eat_pulse, and the counters shall not change.
REQ-028 dots_left shall never underflow. If a map would hold more than 255 dots, the count saturates at 255.

Reset
REQ-029 When rst_n=0 at a pclk edge:
  - state shall become INIT with i=0;
  - dots_left=0, score_bcd=000;
  - eat_pulse=0, level_clear=0, query_dot=0;
  - busy=1.
REQ-030 Reset asserted mid-INIT or mid-EAT shall abandon the operation. The map is then rebuilt from DOT_FILE.

Structure
REQ-031 The shared package shall hold TILES_X=28, TILES_Y=36, N_TILES=1008 and the FSM state encoding.
REQ-032 The single sub-module shall be dot_rom (N_TILES x 1, loaded from DOT_FILE, synchronous read). INIT pipelines its one-cycle latency.

Verification
REQ-033 Reset release with a map of 244 dots: busy=1 for 1008 cycles, then busy=0 and dots_left=244.
REQ-034 Tile (1,4) holds a dot, tick at T: eat_pulse at T+3, dots_left goes 244 to 243, score_bcd goes 000 to 001. On the next cycle, query_index=113 gives query_dot=0.
REQ-035 Repeat a tick on tile (1,4): no eat_pulse, and the counters are unchanged.
REQ-036 score_bcd=009 and eat: 010. score_bcd=999 and eat: 000.
REQ-037 Map with one dot at index 0 and tick at (0,0): eat_pulse and level_clear pulse together, busy=1 for 1008 cycles, then dots_left=1.
REQ-038 Ticks with pac_valid=0 or pac_tile_y=36, frame_tick during INIT, and rst_n=0 mid-INIT: no state change, except that reset restarts INIT at i=0.
